display_scan_mux: RTL and testbench

DISPLAY_SCAN_MUX -- requirements
Module: display_scan_mux

---
 rtl/display_scan_mux.sv | 159 +++++++++++++++
 tb/tb_display_scan_mux.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_mux.sv
// display_scan_mux: time-multiplexed scan driver for DIGITS hex digits.
// Each digit slot is a GAP phase (all anodes off, DEADTIME cycles) followed by
// a SHOW phase (PRESCALE cycles). New values are staged in a shadow register
// and promoted to the display register only when digit 0 starts lighting, so
// a frame never mixes old and new digits.
// Optional build macro: LEADING_ZERO_BLANK_EN (suppress leading zero digits).
module display_scan_mux #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 1000,
    parameter int DEADTIME = 2
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic [4*DIGITS-1:0]   Value,
    input  logic                  Load,
    input  logic [DIGITS-1:0]     DpMask,
    input  logic                  Blank,
    output logic [3:0]            Hex,
    output logic [DIGITS-1:0]     DigitEn,
    output logic                  Dp,
    output logic                  Frame
);

    localparam int CNT_MAX = (PRESCALE > DEADTIME) ? PRESCALE : DEADTIME;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic {
        GAP  = 1'b0,
        SHOW = 1'b1
    } state_t;

    state_t              state_reg, state_next;
    logic [CW-1:0]       cnt_reg, cnt_next;
    logic [IW-1:0]       idx_reg, idx_next;
    logic                gap_end, show_end;

    logic [4*DIGITS-1:0] shadow_val_reg, shadow_val_next;
    logic [DIGITS-1:0]   shadow_dp_reg, shadow_dp_next;
    logic                pending_reg, pending_next;
    logic [4*DIGITS-1:0] disp_val_reg, disp_val_next;
    logic [DIGITS-1:0]   disp_dp_reg, disp_dp_next;
    logic                copy_en;

    logic [3:0]          hex_next;
    logic [DIGITS-1:0]   digit_en_next;
    logic                dp_next;
    logic                frame_next;
    logic [DIGITS-1:0]   suppress;

    // State register: phase, in-phase cycle counter and digit index
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_reg <= GAP;
            cnt_reg   <= '0;
            idx_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
        end
    end

    // Next-state logic: GAP -> SHOW -> (GAP | SHOW when no dead time), index wraps
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        gap_end    = 1'b0;
        show_end   = 1'b0;
        case (state_reg)
            GAP: begin
                // Reset lands in GAP, so with no dead time it still lasts one cycle
                if (DEADTIME == 0 || cnt_reg == CW'(DEADTIME - 1)) begin
                    gap_end    = 1'b1;
                    state_next = SHOW;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            SHOW: begin
                if (cnt_reg == CW'(PRESCALE - 1)) begin
                    show_end   = 1'b1;
                    cnt_next   = '0;
                    idx_next   = (idx_reg == IW'(DIGITS - 1)) ? '0 : idx_reg + 1'b1;
                    state_next = (DEADTIME == 0) ? SHOW : GAP;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
        endcase
    end

    // Shadow/display staging: promote only when digit 0 begins its SHOW phase;
    // a Load in that same cycle lands in the shadow and waits a frame
    always_comb begin
        copy_en         = (state_next == SHOW) && (idx_next == '0) &&
                          (gap_end || show_end) && pending_reg;
        shadow_val_next = Load ? Value  : shadow_val_reg;
        shadow_dp_next  = Load ? DpMask : shadow_dp_reg;
        pending_next    = Load | (pending_reg & ~copy_en);
        disp_val_next   = copy_en ? shadow_val_reg : disp_val_reg;
        disp_dp_next    = copy_en ? shadow_dp_reg  : disp_dp_reg;
    end

`ifdef LEADING_ZERO_BLANK_EN
    // Digit i is a leading zero when it and every higher digit has a zero
    // nibble and no decimal point; digit 0 always stays lit
    assign suppress[0] = 1'b0;
    for (genvar gi = 1; gi < DIGITS; gi++) begin : g_lead_zero
        assign suppress[gi] = (disp_val_next[4*DIGITS-1:4*gi] == '0) &&
                              (disp_dp_next[DIGITS-1:gi] == '0);
    end
`else
    assign suppress = '0;
`endif

    // Output logic: values presented during the upcoming cycle
    always_comb begin
        hex_next      = Hex;
        dp_next       = Dp;
        digit_en_next = '0;
        frame_next    = show_end && (idx_reg == IW'(DIGITS - 1));
        if (state_next == SHOW) begin
            hex_next = disp_val_next[4*idx_next +: 4];
            dp_next  = disp_dp_next[idx_next];
            if (!Blank && !suppress[idx_next]) begin
                digit_en_next = DIGITS'(1) << idx_next;
            end
        end
    end

    // Data and output registers
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            shadow_val_reg <= '0;
            shadow_dp_reg  <= '0;
            pending_reg    <= 1'b0;
            disp_val_reg   <= '0;
            disp_dp_reg    <= '0;
            Hex            <= '0;
            DigitEn        <= '0;
            Dp             <= 1'b0;
            Frame          <= 1'b0;
        end else begin
            shadow_val_reg <= shadow_val_next;
            shadow_dp_reg  <= shadow_dp_next;
            pending_reg    <= pending_next;
            disp_val_reg   <= disp_val_next;
            disp_dp_reg    <= disp_dp_next;
            Hex            <= hex_next;
            DigitEn        <= digit_en_next;
            Dp             <= dp_next;
            Frame          <= frame_next;
        end
    end

endmodule

// File: tb/tb_display_scan_mux.sv
// tb_display_scan_mux: directed checks for display_scan_mux with
// DIGITS=4, PRESCALE=4, DEADTIME=1 (20-cycle frame) and a second instance
// with DEADTIME=0 (16-cycle frame). Honours LEADING_ZERO_BLANK_EN.
module tb_display_scan_mux;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] value;
    logic        load;
    logic [3:0]  dpmask;
    logic        blank;
    logic [3:0]  hex;
    logic [3:0]  digit_en;
    logic        dp;
    logic        frame;

    logic        rst2_n;
    logic        load2;
    logic [3:0]  hex2;
    logic [3:0]  digit_en2;
    logic        dp2;
    logic        frame2;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    display_scan_mux #(.DIGITS(4), .PRESCALE(4), .DEADTIME(1)) dut (
        .Clk(clk), .Rst_n(rst_n), .Value(value), .Load(load), .DpMask(dpmask),
        .Blank(blank), .Hex(hex), .DigitEn(digit_en), .Dp(dp), .Frame(frame)
    );

    display_scan_mux #(.DIGITS(4), .PRESCALE(4), .DEADTIME(0)) dut_nodead (
        .Clk(clk), .Rst_n(rst2_n), .Value(value), .Load(load2), .DpMask(dpmask),
        .Blank(blank), .Hex(hex2), .DigitEn(digit_en2), .Dp(dp2), .Frame(frame2)
    );

    typedef struct {
        logic [15:0] val;
        logic [3:0]  dpm;
        logic        blk;
        logic [3:0]  en_plain;
        logic [3:0]  en_lzb;
    } vec_t;

    vec_t vecs [7];

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [3:0] EN_ZERO = 4'b0001;
`else
    localparam logic [3:0] EN_ZERO = 4'b1111;
`endif

    // Packed observation: {hex[3:0], en[3:0], dp, frame}
    task automatic check(input string name, input logic [9:0] act,
                         input logic [9:0] exp, input logic [9:0] mask);
        checks++;
        if ((act & mask) === (exp & mask)) begin
            passed++;
        end else begin
            $display("FAIL %s: got {hex,en,dp,frame}=%h_%b_%b_%b, expected %h_%b_%b_%b (mask %h)",
                     name, act[9:6], act[5:2], act[1], act[0],
                     exp[9:6], exp[5:2], exp[1], exp[0], mask);
        end
    endtask

    function automatic logic [9:0] obs();
        return {hex, digit_en, dp, frame};
    endfunction

    // Checks cycles k0..19 of a 20-cycle frame starting at the current cycle,
    // optionally pulsing Load at load_k and changing Blank at blank_k.
    // Returns positioned at cycle 0 (Frame cycle) of the following frame.
    task automatic run_frame(input string tag, input logic [15:0] val,
                             input logic [3:0] dpm, input logic [3:0] enm,
                             input int k0, input int load_k,
                             input logic [15:0] lval, input logic [3:0] ldp,
                             input int blank_k, input logic blank_v);
        for (int k = k0; k < 20; k++) begin
            int slot;
            int pos;
            logic [9:0] exp;
            logic [9:0] mask;
            if (k > k0) begin
                @(posedge clk); #1;
            end
            slot = k / 5;
            pos  = k % 5;
            exp  = '0;
            mask = 10'h3FF;
            if (pos == 0) begin
                if (slot == 0) begin
                    mask[9:6] = 4'h0;
                    mask[1]   = 1'b0;
                end else begin
                    exp[9:6] = val[4*(slot-1) +: 4];
                    exp[1]   = dpm[slot-1];
                end
                exp[0] = (k == 0) && (k0 == 0);
            end else begin
                exp[9:6] = val[4*slot +: 4];
                exp[1]   = dpm[slot];
                if (enm[slot] && !(blank_v && blank_k >= 0 && k > blank_k))
                    exp[5:2] = 4'b0001 << slot;
            end
            check($sformatf("%s k=%0d", tag, k), obs(), exp, mask);
            if (k == load_k) begin
                load   = 1'b1;
                value  = lval;
                dpmask = ldp;
            end else begin
                load = 1'b0;
            end
            if (k == blank_k) blank = blank_v;
        end
        @(posedge clk); #1;
        load = 1'b0;
    endtask

    // Bounded wait for the Frame pulse of the main instance
    task automatic wait_frame(input string tag);
        logic found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (frame) found = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        check({tag, " frame_seen"}, {9'd0, found}, 10'd1, 10'h001);
    endtask

    // From cycle 0 of a frame: stage new inputs, then land on the next Frame cycle
    task automatic transition(input logic [15:0] lval, input logic [3:0] ldp,
                              input logic blank_v);
        @(posedge clk); #1;
        load   = 1'b1;
        value  = lval;
        dpmask = ldp;
        blank  = blank_v;
        @(posedge clk); #1;
        load = 1'b0;
        wait_frame("transition");
    endtask

    initial begin
        vecs[0] = '{16'h1234, 4'b0000, 1'b0, 4'b1111, 4'b1111};
        vecs[1] = '{16'hABCD, 4'b0101, 1'b0, 4'b1111, 4'b1111};
        vecs[2] = '{16'h0050, 4'b0000, 1'b0, 4'b1111, 4'b0011};
        vecs[3] = '{16'h0000, 4'b0000, 1'b0, 4'b1111, 4'b0001};
        vecs[4] = '{16'h0000, 4'b0100, 1'b0, 4'b1111, 4'b0111};
        vecs[5] = '{16'h0F00, 4'b0000, 1'b1, 4'b0000, 4'b0000};
        vecs[6] = '{16'h8000, 4'b1000, 1'b0, 4'b1111, 4'b1111};

        // Reset with a Load held active: reset must win
        rst_n  = 1'b0;
        rst2_n = 1'b0;
        load   = 1'b1;
        load2  = 1'b0;
        value  = 16'hFFFF;
        dpmask = 4'hF;
        blank  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset outputs", obs(), 10'd0, 10'h3FF);

        // Release with Load coinciding with the first digit-0 entry: the first
        // frame must still show the cleared display (all zeros)
        rst_n  = 1'b1;
        value  = 16'h1234;
        dpmask = 4'h0;
        @(posedge clk); #1;
        load = 1'b0;
        run_frame("post_reset", 16'h0000, 4'h0, EN_ZERO, 1, -1, '0, '0, -1, 1'b0);

        // 0x1234 frame; 0xABCD loaded during digit 1 must not disturb it
        run_frame("f1234", 16'h1234, 4'h0, 4'b1111, 0, 6, 16'hABCD, 4'h0, -1, 1'b0);
        // New value appears at the next frame; Blank raised mid-frame
        run_frame("fABCD_blank", 16'hABCD, 4'h0, 4'b1111, 0, -1, '0, '0, 7, 1'b1);
        run_frame("blanked", 16'hABCD, 4'h0, 4'b0000, 0, -1, '0, '0, -1, 1'b0);

        // Table of frame contents
        for (int v = 0; v < 7; v++) begin
            logic [3:0] enm;
`ifdef LEADING_ZERO_BLANK_EN
            enm = vecs[v].en_lzb;
`else
            enm = vecs[v].en_plain;
`endif
            transition(vecs[v].val, vecs[v].dpm, vecs[v].blk);
            run_frame($sformatf("vec%0d", v), vecs[v].val, vecs[v].dpm, enm,
                      0, -1, '0, '0, -1, 1'b0);
        end

        // Load in the very cycle of the digit-0 promotion waits one frame
        run_frame("collide", 16'h8000, 4'b1000, 4'b1111, 0, 0, 16'h5A5A, 4'h0, -1, 1'b0);
        run_frame("collide_next", 16'h5A5A, 4'h0, 4'b1111, 0, -1, '0, '0, -1, 1'b0);

        // One-cycle reset in the middle of digit 2's SHOW phase
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("mid_reset outputs", obs(), 10'd0, 10'h3FF);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_frame("after_mid_reset", 16'h0000, 4'h0, EN_ZERO, 1, -1, '0, '0, -1, 1'b0);

        // DEADTIME=0 instance: back-to-back digits, 16-cycle frame
        blank  = 1'b0;
        rst2_n = 1'b1;
        load2  = 1'b1;
        value  = 16'h1234;
        dpmask = 4'h0;
        @(posedge clk); #1;
        load2 = 1'b0;
        begin
            logic found = 1'b0;
            for (int i = 0; i < 40 && !found; i++) begin
                if (frame2) found = 1'b1;
                else begin
                    @(posedge clk); #1;
                end
            end
            check("nodead frame_seen", {9'd0, found}, 10'd1, 10'h001);
        end
        for (int j = 0; j < 17; j++) begin
            logic [9:0] exp;
            int d;
            d   = (j / 4) % 4;
            exp = {value[4*d +: 4], 4'b0001 << d, 1'b0, (j == 0 || j == 16)};
            if (j > 0) begin
                @(posedge clk); #1;
            end
            check($sformatf("nodead j=%0d", j), {hex2, digit_en2, dp2, frame2}, exp, 10'h3FF);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
